// File: rtl/int_wb_pkg.sv
// Shared widths and record types for the integer writeback arbiter.
package int_wb_pkg;

  localparam int INT_WB_N_SRC  = 4;
  localparam int INT_WB_N_PORT = 2;
  localparam int INT_WB_DATA_W = 32;
  localparam int INT_WB_PREG_W = 6;
  localparam int INT_WB_ROB_W  = 6;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [INT_WB_PREG_W-1:0] pdest;
    logic [INT_WB_DATA_W-1:0] wdata;
    logic [INT_WB_ROB_W-1:0]  rob_idx;
  } int_wb_req_t;

  typedef struct packed {
    logic                     we;
    logic [INT_WB_PREG_W-1:0] waddr;
    logic [INT_WB_DATA_W-1:0] wdata;
    logic                     cmt_valid;
    logic [INT_WB_ROB_W-1:0]  rob_idx;
  } int_wb_port_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin arbiter granting up to N_GNT of N_REQ requesters.
module rr_multi_grant
  import int_wb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_GNT = 2,
  parameter int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [PTR_W-1:0]            ptr,
  output logic [N_REQ-1:0]            grant,
  output logic [N_GNT-1:0][N_REQ-1:0] sel,
  output logic [PTR_W-1:0]            next_ptr
);

  always_comb begin
    int         cnt;
    logic [PTR_W-1:0] idx;
    grant    = '0;
    sel      = '0;
    next_ptr = ptr;
    cnt      = 0;
    idx      = '0;
    // k-th grant in rotated scan order lands on output port k
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (req[idx] && cnt < N_GNT) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < N_GNT; p++) begin
          if (cnt == p) sel[p][idx] = 1'b1;
        end
        cnt      = cnt + 1;
        next_ptr = PTR_W'((int'(idx) + 1) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer pipe writeback arbiter: round-robin grant onto registered
// regfile-write, wakeup and ROB-completion ports.
module int_wb_arbiter
  import int_wb_pkg::*;
#(
  parameter int N_SRC  = INT_WB_N_SRC,
  parameter int N_PORT = INT_WB_N_PORT,
  parameter int DATA_W = INT_WB_DATA_W,
  parameter int PREG_W = INT_WB_PREG_W,
  parameter int ROB_W  = INT_WB_ROB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_valid_i,
  input  logic [N_SRC-1:0]         src_we_i,
  input  logic [N_SRC*PREG_W-1:0]  src_pdest_i,
  input  logic [N_SRC*DATA_W-1:0]  src_wdata_i,
  input  logic [N_SRC*ROB_W-1:0]   src_rob_idx_i,
  output logic [N_SRC-1:0]         src_ready_o,
  output logic [N_PORT-1:0]        rf_we_o,
  output logic [N_PORT*PREG_W-1:0] rf_waddr_o,
  output logic [N_PORT*DATA_W-1:0] rf_wdata_o,
  output logic [N_PORT-1:0]        wake_valid_o,
  output logic [N_PORT*PREG_W-1:0] wake_pdest_o,
  output logic [N_PORT-1:0]        cmt_valid_o,
  output logic [N_PORT*ROB_W-1:0]  cmt_rob_idx_o,
  output logic [31:0]              stall_cnt_o
);

  localparam int PTR_W = ptr_w(N_SRC);

  int_wb_req_t                     req_p0 [N_SRC];
  int_wb_port_t                    port_p0 [N_PORT];
  int_wb_port_t                    port_p1 [N_PORT];
  logic [N_SRC-1:0]                grant_p0;
  logic [N_PORT-1:0][N_SRC-1:0]    sel_p0;
  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                rr_ptr_nxt;
  logic [31:0]                     stall_cnt;
  logic                            stall_p0;
  logic                            dup_we_p0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      req_p0[i].valid   = src_valid_i[i];
      req_p0[i].we      = src_we_i[i];
      req_p0[i].pdest   = src_pdest_i[i*PREG_W +: PREG_W];
      req_p0[i].wdata   = src_wdata_i[i*DATA_W +: DATA_W];
      req_p0[i].rob_idx = src_rob_idx_i[i*ROB_W +: ROB_W];
    end
  end

  rr_multi_grant #(
    .N_REQ (N_SRC),
    .N_GNT (N_PORT),
    .PTR_W (PTR_W)
  ) u_grant (
    .req      (src_valid_i),
    .ptr      (rr_ptr),
    .grant    (grant_p0),
    .sel      (sel_p0),
    .next_ptr (rr_ptr_nxt)
  );

  assign src_ready_o = rst ? '0 : grant_p0;
  assign stall_p0    = $countones(src_valid_i) > N_PORT;

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      port_p0[p] = '0;
      for (int i = 0; i < N_SRC; i++) begin
        if (sel_p0[p][i]) begin
          port_p0[p].we        = req_p0[i].we;
          port_p0[p].waddr     = req_p0[i].pdest;
          port_p0[p].wdata     = req_p0[i].wdata;
          port_p0[p].cmt_valid = 1'b1;
          port_p0[p].rob_idx   = req_p0[i].rob_idx;
        end
      end
    end
  end

  // Upstream must never retire two writers of the same pdest together
  always_comb begin
    dup_we_p0 = 1'b0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int q = p + 1; q < N_PORT; q++) begin
        if (port_p0[p].cmt_valid && port_p0[q].cmt_valid && port_p0[p].we &&
            port_p0[q].we && port_p0[p].waddr == port_p0[q].waddr)
          dup_we_p0 = 1'b1;
      end
    end
  end

  a_no_dup_pdest: assert property (@(posedge clk) disable iff (rst) !dup_we_p0);

  // p0 -> p1: registered output ports, pointer and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_PORT; p++) port_p1[p] <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      for (int p = 0; p < N_PORT; p++) port_p1[p] <= port_p0[p];
      rr_ptr <= rr_ptr_nxt;
      if (stall_p0) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      rf_we_o[p]                        = port_p1[p].we;
      wake_valid_o[p]                   = port_p1[p].we;
      rf_waddr_o[p*PREG_W +: PREG_W]    = port_p1[p].waddr;
      wake_pdest_o[p*PREG_W +: PREG_W]  = port_p1[p].waddr;
      rf_wdata_o[p*DATA_W +: DATA_W]    = port_p1[p].wdata;
      cmt_valid_o[p]                    = port_p1[p].cmt_valid;
      cmt_rob_idx_o[p*ROB_W +: ROB_W]   = port_p1[p].rob_idx;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Directed scoreboard bench for int_wb_arbiter (N_SRC=4, N_PORT=2).
module tb_int_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_valid_i;
  logic [3:0]   src_we_i;
  logic [23:0]  src_pdest_i;
  logic [127:0] src_wdata_i;
  logic [23:0]  src_rob_idx_i;
  logic [3:0]   src_ready_o;
  logic [1:0]   rf_we_o;
  logic [11:0]  rf_waddr_o;
  logic [63:0]  rf_wdata_o;
  logic [1:0]   wake_valid_o;
  logic [11:0]  wake_pdest_o;
  logic [1:0]   cmt_valid_o;
  logic [11:0]  cmt_rob_idx_o;
  logic [31:0]  stall_cnt_o;

  logic [5:0]   pd [4];
  logic [31:0]  wd [4];
  logic [5:0]   rb [4];

  typedef struct {
    int          cyc;
    logic [1:0]  we;
    logic [1:0]  cv;
    logic [11:0] wa;
    logic [63:0] wdat;
    logic [11:0] rob;
    logic [31:0] stall;
    logic [1:0]  ptr;
  } exp_t;

  exp_t q [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_pdest_i[i*6 +: 6]    = pd[i];
      src_wdata_i[i*32 +: 32]  = wd[i];
      src_rob_idx_i[i*6 +: 6]  = rb[i];
    end
  end

  int_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid_i   (src_valid_i),
    .src_we_i      (src_we_i),
    .src_pdest_i   (src_pdest_i),
    .src_wdata_i   (src_wdata_i),
    .src_rob_idx_i (src_rob_idx_i),
    .src_ready_o   (src_ready_o),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .wake_valid_o  (wake_valid_o),
    .wake_pdest_o  (wake_pdest_o),
    .cmt_valid_o   (cmt_valid_o),
    .cmt_rob_idx_o (cmt_rob_idx_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // s0/s1: source expected on port0/port1, or -1 for an idle port
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] we,
                       input logic [3:0] rdy, input int s0, input int s1,
                       input logic [31:0] st, input logic [1:0] ptr);
    exp_t e;
    int   s [2];
    rst = r;
    src_valid_i = v;
    src_we_i = we;
    #1;
    chk("ready", {60'd0, src_ready_o}, {60'd0, rdy});
    s[0] = s0;
    s[1] = s1;
    e.cyc = cyc + 1;
    e.we = '0; e.cv = '0; e.wa = '0; e.wdat = '0; e.rob = '0;
    for (int p = 0; p < 2; p++) begin
      if (s[p] >= 0) begin
        e.cv[p]           = 1'b1;
        e.we[p]           = we[s[p]];
        e.wa[p*6 +: 6]    = pd[s[p]];
        e.wdat[p*32 +: 32] = wd[s[p]];
        e.rob[p*6 +: 6]   = rb[s[p]];
      end
    end
    e.stall = st;
    e.ptr = ptr;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rf_we",      {62'd0, rf_we_o},       {62'd0, e.we});
        chk("wake_valid", {62'd0, wake_valid_o},  {62'd0, e.we});
        chk("rf_waddr",   {52'd0, rf_waddr_o},    {52'd0, e.wa});
        chk("wake_pdest", {52'd0, wake_pdest_o},  {52'd0, e.wa});
        chk("rf_wdata",   rf_wdata_o,             e.wdat);
        chk("cmt_valid",  {62'd0, cmt_valid_o},   {62'd0, e.cv});
        chk("cmt_rob",    {52'd0, cmt_rob_idx_o}, {52'd0, e.rob});
        chk("stall_cnt",  {32'd0, stall_cnt_o},   {32'd0, e.stall});
        chk("rr_ptr",     {62'd0, dut.rr_ptr},    {62'd0, e.ptr});
      end
    end
  end

  initial begin
    rst = 1'b1;
    src_valid_i = '0;
    src_we_i = '0;
    pd = '{6'd5, 6'd6, 6'd9, 6'd13};
    wd = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_1234, 32'h3333_3333};
    rb = '{6'd3, 6'd4, 6'd7, 6'd8};
    @(negedge clk);

    // reset, with a record offered during reset that must not be consumed
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, -1, -1, 32'd0, 2'd0);
    drive(1'b1, 4'b0001, 4'b0001, 4'b0000, -1, -1, 32'd0, 2'd0);
    drive(1'b0, 4'b0001, 4'b0001, 4'b0001,  0, -1, 32'd0, 2'd1);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 32'd0, 2'd1);
    // we=0 record completes without a regfile write
    drive(1'b0, 4'b0100, 4'b0000, 4'b0100,  2, -1, 32'd0, 2'd3);
    // pointer wrap from 3
    drive(1'b0, 4'b1001, 4'b1001, 4'b1001,  3,  0, 32'd0, 2'd1);
    drive(1'b0, 4'b0111, 4'b0111, 4'b0110,  1,  2, 32'd1, 2'd3);
    // reset mid-stream
    drive(1'b1, 4'b1111, 4'b1111, 4'b0000, -1, -1, 32'd0, 2'd0);
    pd = '{6'd10, 6'd11, 6'd12, 6'd13};
    drive(1'b0, 4'b1111, 4'b1111, 4'b0011,  0,  1, 32'd1, 2'd2);
    drive(1'b0, 4'b1111, 4'b1111, 4'b1100,  2,  3, 32'd2, 2'd0);
    drive(1'b0, 4'b1111, 4'b1111, 4'b0011,  0,  1, 32'd3, 2'd2);
    // saturation
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    drive(1'b0, 4'b0111, 4'b0111, 4'b0101,  2,  0, 32'hFFFF_FFFF, 2'd1);
    drive(1'b0, 4'b0111, 4'b0111, 4'b0110,  1,  2, 32'hFFFF_FFFF, 2'd3);
    drive(1'b0, 4'b0111, 4'b0111, 4'b0011,  0,  1, 32'hFFFF_FFFF, 2'd2);

    src_valid_i = '0;
    src_we_i = '0;
    repeat (3) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
